oled_spi_receiver: RTL and testbench



---
 rtl/oled_pkg.sv | 28 ++
 rtl/oled_spi_deserialiser.sv | 67 ++++++
 rtl/oled_spi_receiver.sv | 175 +++++++++++++++++
 tb/tb_oled_spi_receiver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared constants and decoder state type for the OLED serial link receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oled_pkg;

  // Command opcodes carried on the link with DnC = 0
  localparam logic [7:0] SET_X     = 8'h15;
  localparam logic [7:0] SET_Y     = 8'h75;
  localparam logic [7:0] SET_PIXEL = 8'h5C;

  // Panel geometry and the default highest legal addresses
  localparam int PICTURE_WIDTH  = 96;
  localparam int PICTURE_HEIGHT = 64;
  localparam int COLUMN_MAX     = PICTURE_WIDTH - 1;
  localparam int ROW_MAX        = PICTURE_HEIGHT - 1;

  // What the next data byte means to the command decoder
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COL_START,
    ST_COL_END,
    ST_ROW_START,
    ST_ROW_END,
    ST_PIX_HI,
    ST_PIX_LO
  } dec_state_t;

endpackage

// File: rtl/oled_spi_deserialiser.sv
// Samples nCS/DnC/SDIN/SCLK on HCLK and reassembles MSB-first bytes.
// Latency: byte_valid one cycle after the HCLK edge that samples the 8th SCLK rise.
// Backpressure: none; a partial byte is dropped (and flagged) when nCS rises.
module oled_spi_deserialiser
  import oled_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       nCS,
  input  logic       DnC,
  input  logic       SDIN,
  input  logic       SCLK,
  input  logic       clear,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dnc,
  output logic       frame_error
);

  logic       r_sclk_q;
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       w_rise;

  // SCLK shares HCLK's clock domain, so a registered copy is enough for edge detect
  assign w_rise = SCLK && !r_sclk_q && !nCS;

  // Shift in bits on each qualified rise; emit the byte on the 8th, drop partials on deselect
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sclk_q   <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dnc   <= 1'b0;
    end else begin
      r_sclk_q   <= SCLK;
      byte_valid <= 1'b0;
      if (nCS) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        r_shift <= {r_shift[5:0], SDIN};
        if (r_bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {r_shift, SDIN};
          byte_dnc   <= DnC;
          r_bit_cnt  <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  // Sticky flag: chip select released with a byte half received; clear takes priority
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      frame_error <= 1'b0;
    end else if (clear) begin
      frame_error <= 1'b0;
    end else if (nCS && (r_bit_cnt != 3'd0)) begin
      frame_error <= 1'b1;
    end
  end

endmodule

// File: rtl/oled_spi_receiver.sv
// Decodes SetX/SetY/SetPixel from the OLED link and emits one pulse per written pixel.
// Latency: window updates and pixel_valid one cycle after byte_valid.
// Backpressure: none; the link must not exceed one byte per 16 HCLK cycles.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int ColumnMax = COLUMN_MAX,
  parameter int RowMax    = ROW_MAX
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        nCS,
  input  logic        DnC,
  input  logic        SDIN,
  input  logic        SCLK,
  input  logic        clear,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dnc,
  output logic        pixel_valid,
  output logic [6:0]  pixel_x,
  output logic [5:0]  pixel_y,
  output logic [15:0] pixel_colour,
  output logic [6:0]  col_start,
  output logic [6:0]  col_end,
  output logic [5:0]  row_start,
  output logic [5:0]  row_end,
  output logic [15:0] pixel_count,
  output logic        frame_error,
  output logic        unknown_cmd
);

  localparam logic [7:0] COL_MAX_B = 8'(ColumnMax);
  localparam logic [7:0] ROW_MAX_B = 8'(RowMax);
  localparam logic [6:0] COL_MAX_X = 7'(ColumnMax);
  localparam logic [5:0] ROW_MAX_Y = 6'(RowMax);

  dec_state_t r_state;
  dec_state_t w_next_state;
  logic [6:0] r_x;
  logic [5:0] r_y;
  logic [7:0] r_pix_hi;
  logic [6:0] w_col_clamp;
  logic [5:0] w_row_clamp;
  logic [6:0] w_x_adv;
  logic [5:0] w_y_adv;
  logic       w_cmd_unknown;
  logic       w_pix_write;

  oled_spi_deserialiser u_deser (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .nCS         (nCS),
    .DnC         (DnC),
    .SDIN        (SDIN),
    .SCLK        (SCLK),
    .clear       (clear),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_dnc    (byte_dnc),
    .frame_error (frame_error)
  );

  // Out-of-range addresses saturate at the panel edge
  assign w_col_clamp   = (byte_data > COL_MAX_B) ? COL_MAX_X : byte_data[6:0];
  assign w_row_clamp   = (byte_data > ROW_MAX_B) ? ROW_MAX_Y : byte_data[5:0];
  assign w_pix_write   = byte_valid && byte_dnc && (r_state == ST_PIX_LO);
  assign w_cmd_unknown = byte_valid && !byte_dnc && (byte_data != SET_X) &&
                         (byte_data != SET_Y) && (byte_data != SET_PIXEL);

  // Raster pointer advance; inverted windows still wrap at the panel edge
  always_comb begin
    w_x_adv = r_x;
    w_y_adv = r_y;
    if (r_x == col_end) begin
      w_x_adv = col_start;
      if (r_y == row_end)        w_y_adv = row_start;
      else if (r_y == ROW_MAX_Y) w_y_adv = '0;
      else                       w_y_adv = r_y + 6'd1;
    end else if (r_x == COL_MAX_X) begin
      w_x_adv = '0;
    end else begin
      w_x_adv = r_x + 7'd1;
    end
  end

  // Decoder state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state: commands restart decoding from any state, data bytes step argument parsing
  always_comb begin
    w_next_state = r_state;
    if (byte_valid) begin
      if (!byte_dnc) begin
        case (byte_data)
          SET_X:     w_next_state = ST_COL_START;
          SET_Y:     w_next_state = ST_ROW_START;
          SET_PIXEL: w_next_state = ST_PIX_HI;
          default:   w_next_state = ST_IDLE;
        endcase
      end else begin
        case (r_state)
          ST_COL_START: w_next_state = ST_COL_END;
          ST_COL_END:   w_next_state = ST_IDLE;
          ST_ROW_START: w_next_state = ST_ROW_END;
          ST_ROW_END:   w_next_state = ST_IDLE;
          ST_PIX_HI:    w_next_state = ST_PIX_LO;
          ST_PIX_LO:    w_next_state = ST_PIX_HI;
          default:      w_next_state = ST_IDLE;
        endcase
      end
    end
  end

  // Window, pointer and pixel output updates driven by data bytes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_start    <= '0;
      col_end      <= COL_MAX_X;
      row_start    <= '0;
      row_end      <= ROW_MAX_Y;
      r_x          <= '0;
      r_y          <= '0;
      r_pix_hi     <= '0;
      pixel_valid  <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      pixel_colour <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (byte_valid && byte_dnc) begin
        case (r_state)
          ST_COL_START: col_start <= w_col_clamp;
          ST_COL_END: begin
            col_end <= w_col_clamp;
            r_x     <= col_start;
          end
          ST_ROW_START: row_start <= w_row_clamp;
          ST_ROW_END: begin
            row_end <= w_row_clamp;
            r_y     <= row_start;
          end
          ST_PIX_HI: r_pix_hi <= byte_data;
          ST_PIX_LO: begin
            pixel_valid  <= 1'b1;
            pixel_x      <= r_x;
            pixel_y      <= r_y;
            pixel_colour <= {r_pix_hi, byte_data};
            r_x          <= w_x_adv;
            r_y          <= w_y_adv;
          end
          default: ;
        endcase
      end
    end
  end

  // Pixel counter and unknown-command flag; clear beats a same-cycle update
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pixel_count <= '0;
      unknown_cmd <= 1'b0;
    end else if (clear) begin
      pixel_count <= '0;
      unknown_cmd <= 1'b0;
    end else begin
      if (w_pix_write)   pixel_count <= pixel_count + 16'd1;
      if (w_cmd_unknown) unknown_cmd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Randomised bench for oled_spi_receiver against a byte-level protocol model.
// Latency: pulses matched in order through expectation queues.
// Backpressure: none; stimulus paced at >= 16 HCLK per byte.
module tb_oled_spi_receiver;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        nCS = 1'b1, DnC = 1'b0, SDIN = 1'b0, SCLK = 1'b0, clear = 1'b0;
  logic        byte_valid, byte_dnc, pixel_valid, frame_error, unknown_cmd;
  logic [7:0]  byte_data;
  logic [6:0]  pixel_x, col_start, col_end;
  logic [5:0]  pixel_y, row_start, row_end;
  logic [15:0] pixel_colour, pixel_count;

  oled_spi_receiver dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .nCS(nCS), .DnC(DnC), .SDIN(SDIN), .SCLK(SCLK),
    .clear(clear), .byte_valid(byte_valid), .byte_data(byte_data), .byte_dnc(byte_dnc),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_colour(pixel_colour), .col_start(col_start), .col_end(col_end),
    .row_start(row_start), .row_end(row_end), .pixel_count(pixel_count),
    .frame_error(frame_error), .unknown_cmd(unknown_cmd)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-level protocol meaning) ----------------
  localparam int EXP_NOTHING = 0, EXP_COL_A = 1, EXP_COL_B = 2, EXP_ROW_A = 3,
                 EXP_ROW_B = 4, EXP_COLOUR_HI = 5, EXP_COLOUR_LO = 6;
  int m_expect, m_cs, m_ce, m_rs, m_re, m_x, m_y, m_hi, m_count;
  bit m_ferr, m_unk;
  logic [8:0]  exp_bytes[$];
  logic [28:0] exp_pix[$];
  int n_bytes, n_pix;
  int last_x, last_y, last_col;

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_expect = EXP_NOTHING;
    m_cs = 0; m_ce = 95; m_rs = 0; m_re = 63; m_x = 0; m_y = 0; m_hi = 0;
    m_count = 0; m_ferr = 0; m_unk = 0;
    exp_bytes.delete();
    exp_pix.delete();
  endtask

  task automatic model_byte(input bit dnc, input logic [7:0] d);
    exp_bytes.push_back({dnc, d});
    if (!dnc) begin
      case (d)
        8'h15:   m_expect = EXP_COL_A;
        8'h75:   m_expect = EXP_ROW_A;
        8'h5C:   m_expect = EXP_COLOUR_HI;
        default: begin m_expect = EXP_NOTHING; m_unk = 1; end
      endcase
    end else begin
      case (m_expect)
        EXP_COL_A: begin m_cs = clampi(int'(d), 95); m_expect = EXP_COL_B; end
        EXP_COL_B: begin m_ce = clampi(int'(d), 95); m_x = m_cs; m_expect = EXP_NOTHING; end
        EXP_ROW_A: begin m_rs = clampi(int'(d), 63); m_expect = EXP_ROW_B; end
        EXP_ROW_B: begin m_re = clampi(int'(d), 63); m_y = m_rs; m_expect = EXP_NOTHING; end
        EXP_COLOUR_HI: begin m_hi = int'(d); m_expect = EXP_COLOUR_LO; end
        EXP_COLOUR_LO: begin
          exp_pix.push_back({7'(m_x), 6'(m_y), 8'(m_hi), d});
          m_count = (m_count + 1) % 65536;
          if (m_x == m_ce) begin
            m_x = m_cs;
            m_y = (m_y == m_re) ? m_rs : (m_y + 1) % 64;
          end else begin
            m_x = (m_x + 1) % 96;
          end
          m_expect = EXP_COLOUR_HI;
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- output monitors ----------------
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (byte_valid) begin
        n_bytes++;
        if (exp_bytes.size() == 0) chk("byte_unexpected", {23'd0, byte_dnc, byte_data}, 32'h1FF);
        else chk("byte", {23'd0, byte_dnc, byte_data}, {23'd0, exp_bytes.pop_front()});
      end
      if (pixel_valid) begin
        n_pix++;
        last_x = int'(pixel_x); last_y = int'(pixel_y); last_col = int'(pixel_colour);
        if (exp_pix.size() == 0) chk("pixel_unexpected", {3'd0, pixel_x, pixel_y, pixel_colour}, 32'hFFFFFFFF);
        else chk("pixel", {3'd0, pixel_x, pixel_y, pixel_colour}, {3'd0, exp_pix.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    SDIN = b;
    SCLK = 1'b0;
    cyc($urandom_range(1, 2));
    SCLK = 1'b1;
    cyc($urandom_range(1, 2));
  endtask

  task automatic send_byte(input bit dnc, input logic [7:0] d);
    logic [7:0] v;
    v = d;
    model_byte(dnc, d);
    nCS = 1'b0;
    DnC = dnc;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    SCLK = 1'b0;
    cyc(2);
    if ($urandom_range(0, 7) == 0) begin
      nCS = 1'b1;
      cyc(1);
    end
  endtask

  task automatic send_partial(input int nbits);
    nCS = 1'b0;
    DnC = 1'($urandom_range(0, 1));
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic abort_partial();
    SCLK = 1'b0;
    nCS  = 1'b1;
    m_ferr = 1;
    cyc(2);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    nCS = 1'b1; SCLK = 1'b0; SDIN = 1'b0; DnC = 1'b0; clear = 1'b0;
    cyc(3);
    model_reset();
    HRESETn = 1'b1;
    cyc(2);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    m_count = 0; m_ferr = 0; m_unk = 0;
    cyc(1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_col_start"}, 32'(col_start), 32'(m_cs));
    chk({tag, "_col_end"}, 32'(col_end), 32'(m_ce));
    chk({tag, "_row_start"}, 32'(row_start), 32'(m_rs));
    chk({tag, "_row_end"}, 32'(row_end), 32'(m_re));
    chk({tag, "_count"}, 32'(pixel_count), 32'(m_count));
    chk({tag, "_frame_error"}, 32'(frame_error), 32'(m_ferr));
    chk({tag, "_unknown_cmd"}, 32'(unknown_cmd), 32'(m_unk));
  endtask

  initial begin
    model_reset();
    n_bytes = 0; n_pix = 0; last_x = -1; last_y = -1; last_col = -1;
    do_reset();

    // reset values
    chk("rst_byte_valid", 32'(byte_valid), 0);
    chk("rst_byte_data", 32'(byte_data), 0);
    chk("rst_pixel_valid", 32'(pixel_valid), 0);
    chk("rst_col_start", 32'(col_start), 0);
    chk("rst_col_end", 32'(col_end), 95);
    chk("rst_row_start", 32'(row_start), 0);
    chk("rst_row_end", 32'(row_end), 63);
    chk("rst_count", 32'(pixel_count), 0);
    chk("rst_flags", {30'd0, frame_error, unknown_cmd}, 0);

    // column window, no pixel produced
    send_byte(0, 8'h15); send_byte(1, 8'h0A); send_byte(1, 8'h11);
    chk("setx_col_start", 32'(col_start), 10);
    chk("setx_col_end", 32'(col_end), 17);
    chk("setx_no_pixel", 32'(n_pix), 0);

    // 8 x 13 window filled exactly once
    send_byte(0, 8'h75); send_byte(1, 8'h0A); send_byte(1, 8'h16);
    send_byte(0, 8'h5C);
    for (int i = 0; i < 104; i++) begin
      send_byte(1, 8'h06); send_byte(1, 8'h3C);
    end
    chk("fill_pulses", 32'(n_pix), 104);
    chk("fill_last_x", 32'(last_x), 17);
    chk("fill_last_y", 32'(last_y), 22);
    chk("fill_colour", 32'(last_col), 32'h063C);
    chk("fill_count", 32'(pixel_count), 104);
    send_byte(1, 8'h06); send_byte(1, 8'h3C);
    chk("wrap_x", 32'(last_x), 10);
    chk("wrap_y", 32'(last_y), 10);

    // clamping of an out-of-range column
    send_byte(0, 8'h15); send_byte(1, 8'hC8); send_byte(1, 8'hC8);
    chk("clamp_col_start", 32'(col_start), 95);
    chk("clamp_col_end", 32'(col_end), 95);

    // deselect mid-byte then a full command
    send_partial(5);
    abort_partial();
    n_bytes = 0;
    send_byte(0, 8'h75);
    chk("ferr_flag", 32'(frame_error), 1);
    chk("ferr_one_byte", 32'(n_bytes), 1);

    // unknown command aborts a pixel, decoder idles
    n_pix = 0;
    send_byte(0, 8'h5C); send_byte(1, 8'hFF); send_byte(0, 8'hAF);
    chk("unk_flag", 32'(unknown_cmd), 1);
    chk("unk_no_pixel", 32'(n_pix), 0);
    send_byte(1, 8'h05); send_byte(1, 8'h05);
    chk("unk_idle_no_pixel", 32'(n_pix), 0);
    check_state("unk");
    pulse_clear();
    chk("clr_unknown", 32'(unknown_cmd), 0);
    chk("clr_frame_error", 32'(frame_error), 0);
    chk("clr_count", 32'(pixel_count), 0);

    // reset in the middle of a pixel stream and a byte
    send_byte(0, 8'h5C); send_byte(1, 8'h12);
    send_partial(3);
    do_reset();
    n_pix = 0;
    send_byte(0, 8'h5C); send_byte(1, 8'hFF); send_byte(1, 8'hFF);
    chk("post_rst_pulses", 32'(n_pix), 1);
    chk("post_rst_x", 32'(last_x), 0);
    chk("post_rst_y", 32'(last_y), 0);
    chk("post_rst_colour", 32'(last_col), 32'hFFFF);
    chk("post_rst_count", 32'(pixel_count), 1);

    // randomised command streams
    for (int op = 0; op < 120; op++) begin
      case ($urandom_range(0, 11))
        0, 1: begin
          send_byte(0, 8'h15);
          send_byte(1, 8'($urandom_range(0, 127)));
          send_byte(1, 8'($urandom_range(0, 255)));
        end
        2, 3: begin
          send_byte(0, 8'h75);
          send_byte(1, 8'($urandom_range(0, 80)));
          send_byte(1, 8'($urandom_range(0, 255)));
        end
        4: begin
          logic [7:0] c;
          c = 8'($urandom_range(0, 255));
          if (c == 8'h15 || c == 8'h75 || c == 8'h5C) c = 8'hAF;
          send_byte(0, c);
        end
        5: send_byte(1, 8'($urandom_range(0, 255)));
        6: begin
          send_partial($urandom_range(1, 7));
          abort_partial();
        end
        7: pulse_clear();
        default: begin
          send_byte(0, 8'h5C);
          for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
            send_byte(1, 8'($urandom_range(0, 255)));
            send_byte(1, 8'($urandom_range(0, 255)));
          end
          if ($urandom_range(0, 3) == 0) send_byte(1, 8'($urandom_range(0, 255)));
        end
      endcase
      check_state("rnd");
    end

    cyc(4);
    chk("bytes_drained", 32'(exp_bytes.size()), 0);
    chk("pixels_drained", 32'(exp_pix.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
